elixirchip_es1_spu_op_acc: RTL and testbench

- SPU accumulator op. Sums a stream of `s_data` words into a running total and emits the total, carry/overflow flags and a qualifying valid.
- Sits directly upstream of the SPU register op: `m_data`/`m_valid` feed that op's `s_data`/`s_valid`, so a total can be latched and held.
- Same cke/clear/valid operand protocol as the other SPU ops; total latency is set by LATENCY.

---
 rtl/elixirchip_es1_spu_op_acc.sv | 152 +++++++++++++++
 tb/tb_elixirchip_es1_spu_op_acc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_acc.sv
// SPU accumulator op: sums a stream of operands into a running total with carry,
// sticky overflow and optional saturation, then delays the result LATENCY-1 extra stages.
module elixirchip_es1_spu_op_acc #(
    parameter int                   LATENCY    = 1,
    parameter int                   DATA_BITS  = 8,
    parameter                       SIGNED     = "false",
    parameter                       SATURATE   = "false",
    parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
    parameter                       DEVICE     = "RTL",
    parameter                       SIMULATION = "false",
    parameter                       DEBUG      = "false"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_clear,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_carry,
    output logic                 m_overflow,
    output logic                 m_valid
);

    localparam bit IS_SIGNED = (SIGNED == "true");
    localparam bit IS_SAT    = (SATURATE == "true");
    localparam int MSB       = DATA_BITS - 1;
    localparam logic [DATA_BITS-1:0] SMAX = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic [DATA_BITS-1:0] SMIN = {1'b1, {(DATA_BITS-1){1'b0}}};

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("LATENCY must be >= 1");
        end
        if (DEVICE == "") begin : g_bad_device
            $error("DEVICE must not be empty");
        end
        if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
            $error("SIMULATION must be \"true\" or \"false\"");
        end
        if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
            $error("DEBUG must be \"true\" or \"false\"");
        end
    endgenerate

    logic [DATA_BITS-1:0] r_acc;
    logic                 r_carry;
    logic                 r_ovf;
    logic                 r_valid;

    logic [DATA_BITS-1:0] w_base;
    logic [DATA_BITS:0]   w_sum;
    logic                 w_carry;
    logic                 w_addOvf;
    logic [DATA_BITS-1:0] w_result;

    // A clear with a sample restarts the sum from CLEAR_DATA instead of the held total.
    always_comb begin
        w_base  = s_clear ? CLEAR_DATA : r_acc;
        w_sum   = {1'b0, w_base} + {1'b0, s_data};
        w_carry = w_sum[DATA_BITS];
        if (IS_SIGNED) begin
            w_addOvf = (w_base[MSB] == s_data[MSB]) && (w_sum[MSB] != w_base[MSB]);
        end else begin
            w_addOvf = w_carry;
        end
        w_result = w_sum[DATA_BITS-1:0];
        if (IS_SAT && w_addOvf) begin
            if (IS_SIGNED) begin
                w_result = w_base[MSB] ? SMIN : SMAX;
            end else begin
                w_result = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (cke) begin
            case ({s_clear, s_valid})
                2'b10: begin
                    r_acc   <= CLEAR_DATA;
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_valid <= 1'b0;
                end
                2'b11: begin
                    r_acc   <= w_result;
                    r_carry <= w_carry;
                    r_ovf   <= w_addOvf;
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    r_acc   <= w_result;
                    r_carry <= w_carry;
                    r_ovf   <= r_ovf | w_addOvf;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (LATENCY <= 1) begin : g_direct
            assign m_data     = r_acc;
            assign m_carry    = r_carry;
            assign m_overflow = r_ovf;
            assign m_valid    = r_valid;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] r_pData  [1:LATENCY-1];
            logic                 r_pCarry [1:LATENCY-1];
            logic                 r_pOvf   [1:LATENCY-1];
            logic                 r_pValid [1:LATENCY-1];

            // All four outputs share one delay line so they stay aligned.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 1; i < LATENCY; i++) begin
                        r_pData[i]  <= '0;
                        r_pCarry[i] <= 1'b0;
                        r_pOvf[i]   <= 1'b0;
                        r_pValid[i] <= 1'b0;
                    end
                end else if (cke) begin
                    r_pData[1]  <= r_acc;
                    r_pCarry[1] <= r_carry;
                    r_pOvf[1]   <= r_ovf;
                    r_pValid[1] <= r_valid;
                    for (int i = 2; i < LATENCY; i++) begin
                        r_pData[i]  <= r_pData[i-1];
                        r_pCarry[i] <= r_pCarry[i-1];
                        r_pOvf[i]   <= r_pOvf[i-1];
                        r_pValid[i] <= r_pValid[i-1];
                    end
                end
            end

            assign m_data     = r_pData[LATENCY-1];
            assign m_carry    = r_pCarry[LATENCY-1];
            assign m_overflow = r_pOvf[LATENCY-1];
            assign m_valid    = r_pValid[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Directed bench for the SPU accumulator: several configurations share one
// stimulus bus and each scenario checks the instance it targets.
module tb_elixirchip_es1_spu_op_acc;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic [7:0] sData;
    logic       sClear;
    logic       sValid;

    int nAsserts  = 0;
    int nFailures = 0;

    logic [7:0] dW, dS, dSS, dL3, dC, dL2;
    logic       cW, cS, cSS, cL3, cC, cL2;
    logic       oW, oS, oSS, oL3, oC, oL2;
    logic       vW, vS, vSS, vL3, vC, vL2;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .SIGNED("false"), .SATURATE("false"), .CLEAR_DATA(8'd0))
        uWrap (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
               .m_data(dW), .m_carry(cW), .m_overflow(oW), .m_valid(vW));

    elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .SIGNED("false"), .SATURATE("true"), .CLEAR_DATA(8'd0))
        uSat (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
              .m_data(dS), .m_carry(cS), .m_overflow(oS), .m_valid(vS));

    elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .SIGNED("true"), .SATURATE("true"), .CLEAR_DATA(8'd0))
        uSSat (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
               .m_data(dSS), .m_carry(cSS), .m_overflow(oSS), .m_valid(vSS));

    elixirchip_es1_spu_op_acc #(.LATENCY(3), .DATA_BITS(8), .SIGNED("false"), .SATURATE("false"), .CLEAR_DATA(8'd0))
        uLat3 (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
               .m_data(dL3), .m_carry(cL3), .m_overflow(oL3), .m_valid(vL3));

    elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .SIGNED("false"), .SATURATE("false"), .CLEAR_DATA(8'd10))
        uClr (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
              .m_data(dC), .m_carry(cC), .m_overflow(oC), .m_valid(vC));

    elixirchip_es1_spu_op_acc #(.LATENCY(2), .DATA_BITS(8), .SIGNED("false"), .SATURATE("false"), .CLEAR_DATA(8'd0))
        uLat2 (.clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear), .s_valid(sValid),
               .m_data(dL2), .m_carry(cL2), .m_overflow(oL2), .m_valid(vL2));

    // Present one input set, let one rising edge take it, then settle before checking.
    task automatic applyStimulus(input logic [7:0] d, input logic c, input logic v);
        sData  = d;
        sClear = c;
        sValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFailures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset  = 1'b1;
        cke    = 1'b1;
        sData  = 8'd0;
        sClear = 1'b0;
        sValid = 1'b0;
        applyStimulus(8'd0, 1'b0, 1'b0);
        applyStimulus(8'd0, 1'b0, 1'b0);
        reset = 1'b0;

        checkOutput("reset wrap data",  dW, 8'd0);
        checkOutput("reset wrap valid", 8'(vW), 8'd0);
        checkOutput("reset wrap ovf",   8'(oW), 8'd0);
        checkOutput("reset wrap carry", 8'(cW), 8'd0);
        checkOutput("reset lat3 data",  dL3, 8'd0);
        checkOutput("reset lat3 valid", 8'(vL3), 8'd0);

        // Unsigned wrap and saturate side by side.
        applyStimulus(8'd0, 1'b1, 1'b0);
        applyStimulus(8'd100, 1'b0, 1'b1);
        checkOutput("wrap s1 data",  dW, 8'd100);
        checkOutput("wrap s1 carry", 8'(cW), 8'd0);
        checkOutput("wrap s1 valid", 8'(vW), 8'd1);
        checkOutput("sat s1 data",   dS, 8'd100);
        applyStimulus(8'd100, 1'b0, 1'b1);
        checkOutput("wrap s2 data",  dW, 8'd200);
        checkOutput("wrap s2 carry", 8'(cW), 8'd0);
        checkOutput("sat s2 data",   dS, 8'd200);
        applyStimulus(8'd100, 1'b0, 1'b1);
        checkOutput("wrap s3 data",  dW, 8'd44);
        checkOutput("wrap s3 carry", 8'(cW), 8'd1);
        checkOutput("wrap s3 ovf",   8'(oW), 8'd1);
        checkOutput("wrap s3 valid", 8'(vW), 8'd1);
        checkOutput("sat s3 data",   dS, 8'd255);
        checkOutput("sat s3 ovf",    8'(oS), 8'd1);
        applyStimulus(8'd10, 1'b0, 1'b1);
        checkOutput("sat s4 data",   dS, 8'd255);
        checkOutput("sat s4 ovf",    8'(oS), 8'd1);
        checkOutput("wrap s4 data",  dW, 8'd54);
        checkOutput("wrap s4 carry", 8'(cW), 8'd0);
        checkOutput("wrap s4 ovf sticky", 8'(oW), 8'd1);
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("wrap idle valid", 8'(vW), 8'd0);
        checkOutput("wrap idle hold",  dW, 8'd54);

        // Signed saturation at the positive limit, then a negative sample.
        applyStimulus(8'd0, 1'b1, 1'b0);
        applyStimulus(8'h70, 1'b0, 1'b1);
        checkOutput("ssat s1 data", dSS, 8'h70);
        checkOutput("ssat s1 ovf",  8'(oSS), 8'd0);
        applyStimulus(8'h20, 1'b0, 1'b1);
        checkOutput("ssat s2 data",  dSS, 8'h7F);
        checkOutput("ssat s2 ovf",   8'(oSS), 8'd1);
        checkOutput("ssat s2 carry", 8'(cSS), 8'd0);
        applyStimulus(8'h80, 1'b0, 1'b1);
        checkOutput("ssat s3 data", dSS, 8'hFF);
        checkOutput("ssat s3 ovf",  8'(oSS), 8'd1);
        applyStimulus(8'd0, 1'b1, 1'b0);
        checkOutput("ssat clr data",  dSS, 8'd0);
        checkOutput("ssat clr ovf",   8'(oSS), 8'd0);
        checkOutput("ssat clr valid", 8'(vSS), 8'd0);

        // Latency 3 with a two-cycle cke gap after the second sample.
        applyStimulus(8'd0, 1'b0, 1'b0);
        applyStimulus(8'd0, 1'b0, 1'b0);
        applyStimulus(8'd5, 1'b0, 1'b1);
        checkOutput("lat3 c0 valid", 8'(vL3), 8'd0);
        applyStimulus(8'd7, 1'b0, 1'b1);
        checkOutput("lat3 c1 valid", 8'(vL3), 8'd0);
        cke = 1'b0;
        applyStimulus(8'd99, 1'b0, 1'b1);
        checkOutput("lat3 gap1 valid", 8'(vL3), 8'd0);
        applyStimulus(8'd99, 1'b0, 1'b1);
        checkOutput("lat3 gap2 valid", 8'(vL3), 8'd0);
        checkOutput("lat3 gap2 data",  dL3, 8'd0);
        cke = 1'b1;
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("lat3 out1 data",  dL3, 8'd5);
        checkOutput("lat3 out1 valid", 8'(vL3), 8'd1);
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("lat3 out2 data",  dL3, 8'd12);
        checkOutput("lat3 out2 valid", 8'(vL3), 8'd1);
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("lat3 out3 valid", 8'(vL3), 8'd0);
        checkOutput("lat3 out3 hold",  dL3, 8'd12);

        // Clear-with-sample restarts from CLEAR_DATA and drops the sticky overflow.
        applyStimulus(8'd0, 1'b1, 1'b0);
        checkOutput("clr init data",  dC, 8'd10);
        applyStimulus(8'd40, 1'b0, 1'b1);
        checkOutput("clr acc50 data", dC, 8'd50);
        applyStimulus(8'd250, 1'b0, 1'b1);
        checkOutput("clr ovf data",   dC, 8'd44);
        checkOutput("clr ovf flag",   8'(oC), 8'd1);
        applyStimulus(8'd3, 1'b1, 1'b1);
        checkOutput("clrv data",  dC, 8'd13);
        checkOutput("clrv ovf",   8'(oC), 8'd0);
        checkOutput("clrv carry", 8'(cC), 8'd0);
        checkOutput("clrv valid", 8'(vC), 8'd1);
        applyStimulus(8'd0, 1'b1, 1'b0);
        checkOutput("clr only data",  dC, 8'd10);
        checkOutput("clr only valid", 8'(vC), 8'd0);

        // Reset while cke=0 on a latency-2 instance mid-accumulation.
        applyStimulus(8'd0, 1'b1, 1'b0);
        applyStimulus(8'd9, 1'b0, 1'b1);
        applyStimulus(8'd9, 1'b0, 1'b1);
        checkOutput("lat2 pre data",  dL2, 8'd9);
        checkOutput("lat2 pre valid", 8'(vL2), 8'd1);
        reset = 1'b1;
        cke   = 1'b0;
        applyStimulus(8'd55, 1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("rst data",  dL2, 8'd0);
        checkOutput("rst valid", 8'(vL2), 8'd0);
        cke = 1'b1;
        applyStimulus(8'd0, 1'b0, 1'b0);
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("rst+2 data",  dL2, 8'd0);
        checkOutput("rst+2 valid", 8'(vL2), 8'd0);
        checkOutput("rst+2 ovf",   8'(oL2), 8'd0);
        checkOutput("rst+2 carry", 8'(cL2), 8'd0);
        applyStimulus(8'd4, 1'b0, 1'b1);
        checkOutput("rst s4 early valid", 8'(vL2), 8'd0);
        applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("rst s4 data",  dL2, 8'd4);
        checkOutput("rst s4 valid", 8'(vL2), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
        $finish;
    end

endmodule
